decode_stage: RTL
=================

Name: decode_stage

Overview:
Registered, parametrised RV32/RV64 instruction decode stage between fetch and execute. It accepts raw instructions with their PC over a valid/ready handshake and decodes them with a combinational decoder. Results go into a DEPTH-entry micro-op queue, which drains to execute over a second valid/ready handshake. Over the single-cycle decoder it adds RV64 W-ops, an optional M extension, optional FENCE/SYSTEM legality, backpressure and flush.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; sets imm/pc width.
DEPTH, 2, micro-op queue entries; power of two, at least 1.
EN_M, 0, 1 makes OP/OP-32 with funct7=0000001 legal (is_muldiv).
EN_SYS, 0, 1 makes MISC-MEM (0001111) and SYSTEM (1110011) legal, decoded as I-type.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
flush  in  1  drop all queued and in-flight entries
in_valid  in  1  fetch offers instruction
in_ready  out  1  stage can accept
in_instr  in  32  raw instruction
in_pc  in  XLEN  instruction PC
out_valid  out  1  head entry valid
out_ready  in  1  execute takes head entry
out_pc  out  XLEN  PC of head
out_op  out  7  opcode
out_rd, out_rs1, out_rs2  out  5 each  register indices
out_funct3  out  3
out_funct7  out  7
out_aluop  out  3  ALU operation select
out_imm  out  XLEN  sign-extended immediate
out_itype  out  3  0 none, 1 U, 2 J, 3 B, 4 I, 5 S, 6 R
out_is_word  out  1  RV64 W-op (0011011/0111011)
out_is_muldiv  out  1  M-extension op
out_illegal  out  1  unknown or disabled encoding
out_count  out  $clog2(DEPTH+1)  queue occupancy

Behaviour:
- Reset, sampled on clk: count=0, pointers=0, out_valid=0. All out_* fields read 0 while the queue is empty.
- Push when in_valid && in_ready; pop when out_valid && out_ready.
- in_ready = (count < DEPTH) && !flush. No combinational path from out_ready to in_ready, so a full queue refuses input even in a pop cycle.
- Latency: an instruction pushed into an empty queue in cycle N has out_valid=1 in cycle N+1. Throughput is one per cycle when out_ready=1.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, FIFO order preserved.
- Flush has priority over push, pop and the queue contents. The next cycle has count=0 and out_valid=0, and the instruction offered during the flush cycle is dropped.
- Field extraction per format, all unused fields forced to 0:
  - U (0110111, 0010111): rd; imm = {instr[31:12], 12'h0} sign-extended to XLEN.
  - J (1101111): rd; imm = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - B (1100011): rs1, rs2, funct3; imm = {instr[31], instr[7], instr[30:25], instr[11:8], 0}; aluop=0.
  - I (1100111, 0000011, 0010011, 0011011 when XLEN=64, and 0001111/1110011 when EN_SYS): rd, rs1, funct3; imm = instr[31:20].
  - S (0100011): rs1, rs2, funct3; imm = {instr[31:25], instr[11:7]}; aluop=0.
  - R (0110011, 0111011 when XLEN=64): rd, rs1, rs2, funct3, funct7; imm=0.
- Every immediate is sign-extended from instr[31] to XLEN.
- aluop = funct3, except aluop=0 for loads, stores, branches, U, J, FENCE and SYSTEM.
- is_word=1 only for 0011011/0111011 with XLEN=64; with XLEN=32 these opcodes are illegal.
- funct7=0000001 on an R opcode: legal with is_muldiv=1 if EN_M=1, else illegal.
- Illegal entries are still queued, in order, with illegal=1, pc and op valid, every other field 0 and itype=0.
- Queue storage is flops; read data is the head entry, no read latency.

Decomposition:
- decode_pkg holds:
  - opcode localparams;
  - itype_e enum with values 0 to 6;
  - parametrised uop_t struct: pc, op, rd, rs1, rs2, funct3, funct7, aluop, imm, itype, is_word, is_muldiv, illegal.
- Sub-module decode_logic is the pure combinational instr -> uop_t decoder, parametrised by XLEN, EN_M and EN_SYS.
- decode_stage wraps decode_logic with the queue and both handshakes.

Test Plan:
- XLEN=32: push 0xFFF10093 (addi x1,x2,-1) into an empty queue, out_ready=1 -> next cycle out_valid=1, rd=1, rs1=2, imm=0xFFFFFFFF, itype=4, aluop=0, funct3=0.
- Push 0x00012083 (lw x1,0(x2)) -> itype=4, funct3=2, aluop=0, imm=0.
- Push 0x022081B3 (mul x3,x1,x2): EN_M=0 -> illegal=1, itype=0, rd=0. EN_M=1 -> itype=6, rd=3, rs1=1, rs2=2, funct7=1, is_muldiv=1.
- DEPTH=2, out_ready=0, offer 3 instructions back-to-back -> two accepted, in_ready=0 from the third cycle, count=2. Raise out_ready -> entries drain in order, third accepted one cycle after the first pop.
- Queue holds 2 entries, flush with in_valid=1 -> next cycle count=0, out_valid=0, offered instruction never appears. Mid-stream reset behaves the same.
- XLEN=64: push 0x0010809B (addiw x1,x1,1) -> is_word=1, imm=0x0000000000000001, itype=4. XLEN=32: same word -> illegal=1.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types for the decode stage.
//   - opcode / funct7 encodings
//   - itype_e : instruction format tag (0 none .. 6 R)
//   - uop_t   : decoded micro-op; pc/imm are sized for the widest datapath
//               (64) and the stage presents only the low XLEN bits.
//   - sext32  : widen a 32-bit immediate to XLEN_MAX by sign extension.
package decode_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    IT_NONE = 3'd0,
    IT_U    = 3'd1,
    IT_J    = 3'd2,
    IT_B    = 3'd3,
    IT_I    = 3'd4,
    IT_S    = 3'd5,
    IT_R    = 3'd6
  } itype_e;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [6:0]          op;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [2:0]          aluop;
    logic [XLEN_MAX-1:0] imm;
    itype_e              itype;
    logic                is_word;
    logic                is_muldiv;
    logic                illegal;
  } uop_t;

  function automatic logic [XLEN_MAX-1:0] sext32(input logic [31:0] v);
    return {{(XLEN_MAX-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/decode_logic.sv
// Pure combinational instruction decoder.
//   instr_i : raw 32-bit instruction
//   pc_i    : instruction PC (XLEN bits), zero-extended into uop_o.pc
//   uop_o   : decoded micro-op; fields a format does not use are 0, and an
//             illegal encoding keeps only pc, op and illegal=1.
module decode_logic
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int EN_M   = 0,
  parameter int EN_SYS = 0
) (
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output uop_t            uop_o
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0]  op, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign op  = instr_i[6:0];
  assign rd  = instr_i[11:7];
  assign f3  = instr_i[14:12];
  assign rs1 = instr_i[19:15];
  assign rs2 = instr_i[24:20];
  assign f7  = instr_i[31:25];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                  instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'h000};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};

  uop_t dec;
  logic illegal;

  always_comb begin
    dec     = '0;
    illegal = 1'b0;
    case (op)
      OP_LUI, OP_AUIPC: begin
        dec.itype = IT_U;
        dec.rd    = rd;
        dec.imm   = sext32(imm_u);
      end
      OP_JAL: begin
        dec.itype = IT_J;
        dec.rd    = rd;
        dec.imm   = sext32(imm_j);
      end
      OP_BRANCH: begin
        dec.itype  = IT_B;
        dec.rs1    = rs1;
        dec.rs2    = rs2;
        dec.funct3 = f3;
        dec.imm    = sext32(imm_b);
      end
      OP_STORE: begin
        dec.itype  = IT_S;
        dec.rs1    = rs1;
        dec.rs2    = rs2;
        dec.funct3 = f3;
        dec.imm    = sext32(imm_s);
      end
      // I-type with no ALU function: address/CSR computation is fixed.
      OP_JALR, OP_LOAD, OP_FENCE, OP_SYSTEM: begin
        if ((op == OP_FENCE || op == OP_SYSTEM) && EN_SYS == 0) begin
          illegal = 1'b1;
        end else begin
          dec.itype  = IT_I;
          dec.rd     = rd;
          dec.rs1    = rs1;
          dec.funct3 = f3;
          dec.imm    = sext32(imm_i);
        end
      end
      OP_IMM, OP_IMM32: begin
        if (op == OP_IMM32 && !RV64) begin
          illegal = 1'b1;
        end else begin
          dec.itype   = IT_I;
          dec.rd      = rd;
          dec.rs1     = rs1;
          dec.funct3  = f3;
          dec.aluop   = f3;
          dec.imm     = sext32(imm_i);
          dec.is_word = (op == OP_IMM32);
        end
      end
      OP_OP, OP_OP32: begin
        // Only the base, alternate (SUB/SRA) and M-extension funct7 are known.
        if ((op == OP_OP32 && !RV64) ||
            !(f7 == F7_BASE || f7 == F7_ALT || (f7 == F7_MULDIV && EN_M != 0))) begin
          illegal = 1'b1;
        end else begin
          dec.itype     = IT_R;
          dec.rd        = rd;
          dec.rs1       = rs1;
          dec.rs2       = rs2;
          dec.funct3    = f3;
          dec.funct7    = f7;
          dec.aluop     = f3;
          dec.is_word   = (op == OP_OP32);
          dec.is_muldiv = (f7 == F7_MULDIV);
        end
      end
      default: illegal = 1'b1;
    endcase

    uop_o = illegal ? uop_t'(0) : dec;
    uop_o.illegal = illegal;
    uop_o.pc      = XLEN_MAX'(pc_i);
    uop_o.op      = op;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes fetch instructions into a DEPTH-entry
// flop-based micro-op queue drained by execute.
//   clk/reset           : rising-edge clock, synchronous active-high reset
//   flush               : drop queue contents and the instruction offered now
//   in_valid/in_ready   : fetch handshake (in_instr, in_pc)
//   out_valid/out_ready : execute handshake; out_* is the head entry, all 0
//                         while the queue is empty
//   out_count           : queue occupancy
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 2,
  parameter int EN_M   = 0,
  parameter int EN_SYS = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [XLEN-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [6:0]                 out_op,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [2:0]                 out_funct3,
  output logic [6:0]                 out_funct7,
  output logic [2:0]                 out_aluop,
  output logic [XLEN-1:0]            out_imm,
  output logic [2:0]                 out_itype,
  output logic                       out_is_word,
  output logic                       out_is_muldiv,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] out_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  uop_t dec_uop;
  uop_t head;
  uop_t mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  decode_logic #(
    .XLEN   (XLEN),
    .EN_M   (EN_M),
    .EN_SYS (EN_SYS)
  ) u_dec (
    .instr_i (in_instr),
    .pc_i    (in_pc),
    .uop_o   (dec_uop)
  );

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // in_ready depends only on registered occupancy and flush, never on
  // out_ready, so a full queue stalls fetch even while execute pops.
  assign in_ready  = (count_q < CW'(DEPTH)) && !flush;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec_uop;
  end

  assign head = out_valid ? mem_q[rd_ptr_q] : uop_t'(0);

  assign out_pc        = head.pc[XLEN-1:0];
  assign out_op        = head.op;
  assign out_rd        = head.rd;
  assign out_rs1       = head.rs1;
  assign out_rs2       = head.rs2;
  assign out_funct3    = head.funct3;
  assign out_funct7    = head.funct7;
  assign out_aluop     = head.aluop;
  assign out_imm       = head.imm[XLEN-1:0];
  assign out_itype     = head.itype;
  assign out_is_word   = head.is_word;
  assign out_is_muldiv = head.is_muldiv;
  assign out_illegal   = head.illegal;
  assign out_count     = count_q;

  // Upper pc/imm bits are redundant when XLEN is narrower than the struct.
  logic unused_hi;
  assign unused_hi = ^{head.pc, head.imm};

endmodule
